// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture inference pipeline.
// Holds the scheduler state encoding, gesture codes and window sizing helper.
package gesture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_READOUT  = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_REPORT   = 3'd4
    } sched_state_e;

    localparam logic [1:0] GEST_UP    = 2'd0;
    localparam logic [1:0] GEST_DOWN  = 2'd1;
    localparam logic [1:0] GEST_LEFT  = 2'd2;
    localparam logic [1:0] GEST_RIGHT = 2'd3;

    function automatic int unsigned window_cycles(input int unsigned clk_freq_hz,
                                                  input int unsigned window_ms);
        return clk_freq_hz / 1000 * window_ms;
    endfunction

endpackage

// File: rtl/window_timer.sv
// Free-running wrap counter with terminal-count pulse; held at zero by clr.
// Latency: tc is combinational from the count register, asserted on the last cycle of each window.
// Backpressure: none; the counter never stalls.
module window_timer #(
    parameter int unsigned CYCLES = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tc
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tc = !clr && (cnt == LAST);

endmodule

// File: rtl/inference_scheduler.sv
// Sequences one inference per observation window: readout, classify, gated report.
// Latency: readout_start one cycle after window end; result_valid one cycle after cls_result_valid.
// Backpressure: none; windows ending while busy are skipped and counted in overrun_count.
module inference_scheduler
    import gesture_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 12_000_000,
    parameter int unsigned WINDOW_MS        = 400,
    parameter int unsigned NUM_CELLS        = 1280,
    parameter int unsigned MIN_EVENT_THRESH = 20,
    parameter int unsigned TIMEOUT_CYCLES   = 4096,
    parameter int unsigned EVT_CNT_BITS     = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    event_accepted,
    output logic                    readout_start,
    output logic                    cls_start,
    input  logic                    readout_valid,
    input  logic                    cls_result_valid,
    input  logic [1:0]              cls_best_class,
    output logic                    result_valid,
    output logic [1:0]              result_class,
    output logic                    result_pass,
    output logic [EVT_CNT_BITS-1:0] window_events,
    output logic [7:0]              overrun_count,
    output logic                    timeout_err,
    output logic [2:0]              state_dbg
);

    localparam int unsigned WINDOW_CYCLES = window_cycles(CLK_FREQ_HZ, WINDOW_MS);
    localparam int BEAT_W = $clog2(NUM_CELLS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(NUM_CELLS - 1);
    localparam logic [TO_W-1:0]         TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [EVT_CNT_BITS-1:0] EVT_MAX   = '1;
    localparam logic [EVT_CNT_BITS-1:0] THRESH    = EVT_CNT_BITS'(MIN_EVENT_THRESH);

    sched_state_e            state;
    logic                    tc;
    logic                    busy;
    logic                    waiting;
    logic [EVT_CNT_BITS-1:0] evt_cnt;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [TO_W-1:0]         to_cnt;

    assign busy      = (state == ST_READOUT) || (state == ST_CLASSIFY) || (state == ST_REPORT);
    assign waiting   = (state == ST_READOUT) || (state == ST_CLASSIFY);
    assign state_dbg = state;

    window_timer #(.CYCLES(WINDOW_CYCLES)) u_window_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_IDLE),
        .tc    (tc)
    );

    // An event landing on the terminal-count cycle seeds the next window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt       <= '0;
            window_events <= '0;
        end else if (state == ST_IDLE) begin
            evt_cnt <= '0;
        end else if (tc) begin
            window_events <= evt_cnt;
            evt_cnt       <= {{(EVT_CNT_BITS-1){1'b0}}, event_accepted};
        end else if (event_accepted && evt_cnt != EVT_MAX) begin
            evt_cnt <= evt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            beat_cnt      <= '0;
            to_cnt        <= '0;
            readout_start <= 1'b0;
            cls_start     <= 1'b0;
            result_valid  <= 1'b0;
            result_class  <= '0;
            result_pass   <= 1'b0;
            overrun_count <= '0;
            timeout_err   <= 1'b0;
        end else begin
            readout_start <= 1'b0;
            cls_start     <= 1'b0;
            result_valid  <= 1'b0;
            if (tc && busy && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
            if (waiting)
                to_cnt <= to_cnt + 1'b1;

            // Timeout outranks both the final beat and a same-cycle result.
            if (waiting && to_cnt == TO_LAST) begin
                timeout_err <= 1'b1;
                state       <= enable ? ST_ACCUM : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enable)
                            state <= ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        if (!enable) begin
                            state <= ST_IDLE;
                        end else if (tc) begin
                            state         <= ST_READOUT;
                            readout_start <= 1'b1;
                            cls_start     <= 1'b1;
                            beat_cnt      <= '0;
                            to_cnt        <= '0;
                        end
                    end
                    ST_READOUT: begin
                        if (readout_valid) begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (beat_cnt == LAST_BEAT)
                                state <= ST_CLASSIFY;
                        end
                    end
                    ST_CLASSIFY: begin
                        if (cls_result_valid) begin
                            result_class <= cls_best_class;
                            result_pass  <= (window_events >= THRESH);
                            result_valid <= 1'b1;
                            state        <= ST_REPORT;
                        end
                    end
                    ST_REPORT: begin
                        state <= enable ? ST_ACCUM : ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inference_scheduler.sv
// Bench for inference_scheduler: table-driven windows plus corner-case sequences.
// A second instance with a long timeout exercises the overrun path.
module tb_inference_scheduler;

    localparam int WIN = 100;
    localparam int S_IDLE = 0, S_ACCUM = 1, S_READOUT = 2, S_CLASSIFY = 3, S_REPORT = 4;

    logic clk = 1'b0;
    logic rst_n, enable, event_accepted, readout_valid, cls_result_valid;
    logic [1:0] cls_best_class;

    logic readout_start, cls_start, result_valid, result_pass, timeout_err;
    logic [1:0] result_class;
    logic [11:0] window_events;
    logic [7:0] overrun_count;
    logic [2:0] state_dbg;

    logic d2_readout_start, d2_cls_start, d2_result_valid, d2_result_pass, d2_timeout_err;
    logic [1:0] d2_result_class;
    logic [11:0] d2_window_events;
    logic [7:0] d2_overrun_count;
    logic [2:0] d2_state_dbg;

    typedef struct packed {
        logic [1:0]  cls;
        logic        pass;
        logic [11:0] ev;
    } exp_t;

    typedef struct {
        int         nev;
        logic [1:0] cls;
        logic       pass;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    vec_t vecs[4];
    int checks = 0;
    int failures = 0;
    int phase = 0;
    int n_rs;

    always #5 clk = ~clk;

    inference_scheduler #(
        .CLK_FREQ_HZ(10000), .WINDOW_MS(10), .NUM_CELLS(8),
        .MIN_EVENT_THRESH(20), .TIMEOUT_CYCLES(40), .EVT_CNT_BITS(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_accepted(event_accepted),
        .readout_start(readout_start), .cls_start(cls_start), .readout_valid(readout_valid),
        .cls_result_valid(cls_result_valid), .cls_best_class(cls_best_class),
        .result_valid(result_valid), .result_class(result_class), .result_pass(result_pass),
        .window_events(window_events), .overrun_count(overrun_count),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    inference_scheduler #(
        .CLK_FREQ_HZ(10000), .WINDOW_MS(10), .NUM_CELLS(8),
        .MIN_EVENT_THRESH(20), .TIMEOUT_CYCLES(150), .EVT_CNT_BITS(12)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_accepted(event_accepted),
        .readout_start(d2_readout_start), .cls_start(d2_cls_start), .readout_valid(readout_valid),
        .cls_result_valid(cls_result_valid), .cls_best_class(cls_best_class),
        .result_valid(d2_result_valid), .result_class(d2_result_class), .result_pass(d2_result_pass),
        .window_events(d2_window_events), .overrun_count(d2_overrun_count),
        .timeout_err(d2_timeout_err), .state_dbg(d2_state_dbg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && result_valid) begin
            if (q1.size() == 0) begin
                chk("dut_unexpected_result_valid", 32'(result_valid), 0);
            end else begin
                e = q1.pop_front();
                chk("dut_result_class", 32'(result_class), 32'(e.cls));
                chk("dut_result_pass", 32'(result_pass), 32'(e.pass));
                chk("dut_window_events", 32'(window_events), 32'(e.ev));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && d2_result_valid) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_result_valid", 32'(d2_result_valid), 0);
            end else begin
                e = q2.pop_front();
                chk("dut2_result_class", 32'(d2_result_class), 32'(e.cls));
                chk("dut2_result_pass", 32'(d2_result_pass), 32'(e.pass));
                chk("dut2_window_events", 32'(d2_window_events), 32'(e.ev));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        phase = (phase + 1) % WIN;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dut_outputs"}, 32'({readout_start, cls_start, result_valid, result_class,
            result_pass, window_events, overrun_count, timeout_err, state_dbg}), 0);
        chk({tag, "_dut2_outputs"}, 32'({d2_readout_start, d2_cls_start, d2_result_valid,
            d2_result_class, d2_result_pass, d2_window_events, d2_overrun_count,
            d2_timeout_err, d2_state_dbg}), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        event_accepted = 1'b0;
        readout_valid = 1'b0;
        cls_result_valid = 1'b0;
        cls_best_class = 2'd0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        enable = 1'b1;
        tick();
        phase = 0;
        chk("enter_accum", 32'(state_dbg), S_ACCUM);
    endtask

    // Drives nev events from the current window phase, closes the window and checks the readout kick.
    task automatic finish_window(input int nev, input logic ev_tc, input int exp_ev);
        while (phase != WIN - 1) begin
            event_accepted = (nev > 0);
            if (nev > 0) nev--;
            tick();
        end
        event_accepted = ev_tc;
        chk("no_readout_on_tc_cycle", 32'(readout_start), 0);
        tick();
        event_accepted = 1'b0;
        chk("readout_start_after_tc", 32'(readout_start), 1);
        chk("cls_start_after_tc", 32'(cls_start), 1);
        chk("state_readout", 32'(state_dbg), S_READOUT);
        chk("latched_window_events", 32'(window_events), 32'(exp_ev));
    endtask

    task automatic beats(input int n);
        readout_valid = 1'b1;
        repeat (n) tick();
        readout_valid = 1'b0;
    endtask

    task automatic give_result(input logic [1:0] cls, input logic pass, input logic [11:0] ev,
                               input logic p1, input logic p2);
        if (p1) q1.push_back('{cls: cls, pass: pass, ev: ev});
        if (p2) q2.push_back('{cls: cls, pass: pass, ev: ev});
        cls_result_valid = 1'b1;
        cls_best_class = cls;
        tick();
        cls_result_valid = 1'b0;
    endtask

    task automatic timeout_case(input logic tie);
        do_reset();
        start_run();
        finish_window(25, 1'b0, 25);
        beats(tie ? 7 : 8);
        while (phase != 39) tick();
        chk("timeout_not_yet", 32'(timeout_err), 0);
        chk("state_before_timeout", 32'(state_dbg), tie ? S_READOUT : S_CLASSIFY);
        readout_valid = tie;
        tick();
        readout_valid = 1'b0;
        chk("timeout_err_at_40", 32'(timeout_err), 1);
        chk("state_after_timeout", 32'(state_dbg), S_ACCUM);
        tick();
        chk("timeout_err_sticky", 32'(timeout_err), 1);
    endtask

    initial begin
        vecs[0] = '{25, 2'd3, 1'b1};
        vecs[1] = '{19, 2'd0, 1'b0};
        vecs[2] = '{20, 2'd1, 1'b1};
        vecs[3] = '{0,  2'd2, 1'b0};

        for (int i = 0; i < 4; i++) begin
            do_reset();
            start_run();
            finish_window(vecs[i].nev, 1'b0, vecs[i].nev);
            beats(8);
            chk("state_classify", 32'(state_dbg), S_CLASSIFY);
            chk("readout_start_one_cycle", 32'(readout_start), 0);
            give_result(vecs[i].cls, vecs[i].pass, 12'(vecs[i].nev), 1'b1, 1'b1);
            chk("state_report", 32'(state_dbg), S_REPORT);
            tick();
            chk("report_to_accum", 32'(state_dbg), S_ACCUM);
            chk("result_valid_one_cycle", 32'(result_valid), 0);
            chk("result_class_held", 32'(result_class), 32'(vecs[i].cls));
        end

        timeout_case(1'b0);
        timeout_case(1'b1);

        // Overrun: result withheld across the next window end on the long-timeout instance.
        do_reset();
        start_run();
        finish_window(25, 1'b0, 25);
        beats(8);
        event_accepted = 1'b1;
        repeat (22) tick();
        event_accepted = 1'b0;
        n_rs = 0;
        while (phase != WIN - 1) begin
            tick();
            n_rs = n_rs + int'(d2_readout_start);
        end
        tick();
        chk("overrun_no_readout_while_busy", 32'(n_rs), 0);
        chk("overrun_no_readout_at_tc", 32'(d2_readout_start), 0);
        chk("overrun_count", 32'(d2_overrun_count), 1);
        chk("overrun_still_classify", 32'(d2_state_dbg), S_CLASSIFY);
        chk("overrun_window_events", 32'(d2_window_events), 22);
        give_result(2'd1, 1'b1, 12'd22, 1'b0, 1'b1);
        chk("overrun_state_report", 32'(d2_state_dbg), S_REPORT);
        tick();
        chk("overrun_back_to_accum", 32'(d2_state_dbg), S_ACCUM);
        while (phase != WIN - 1) tick();
        tick();
        chk("overrun_next_readout", 32'(d2_readout_start), 1);
        chk("overrun_count_stable", 32'(d2_overrun_count), 1);

        // Stray beats/results in ACCUM; event on the TC cycle joins the next window.
        do_reset();
        start_run();
        readout_valid = 1'b1;
        cls_result_valid = 1'b1;
        cls_best_class = 2'd2;
        tick();
        tick();
        readout_valid = 1'b0;
        cls_result_valid = 1'b0;
        chk("stray_state_accum", 32'(state_dbg), S_ACCUM);
        chk("stray_class_ignored", 32'(result_class), 0);
        finish_window(5, 1'b1, 5);
        beats(8);
        give_result(2'd0, 1'b0, 12'd5, 1'b1, 1'b1);
        tick();
        finish_window(19, 1'b0, 20);
        beats(8);
        give_result(2'd1, 1'b1, 12'd20, 1'b1, 1'b1);
        tick();

        // enable dropped mid-readout: sequence completes, then IDLE.
        do_reset();
        start_run();
        finish_window(20, 1'b0, 20);
        enable = 1'b0;
        beats(8);
        give_result(2'd2, 1'b1, 12'd20, 1'b1, 1'b1);
        chk("disable_state_report", 32'(state_dbg), S_REPORT);
        tick();
        chk("disable_to_idle", 32'(state_dbg), S_IDLE);
        chk("disable_class_held", 32'(result_class), 2);
        enable = 1'b1;
        tick();
        chk("reenable_accum", 32'(state_dbg), S_ACCUM);
        enable = 1'b0;
        tick();
        chk("accum_disable_idle", 32'(state_dbg), S_IDLE);

        // Asynchronous reset in the middle of CLASSIFY.
        start_run();
        finish_window(25, 1'b0, 25);
        beats(8);
        chk("pre_reset_classify", 32'(state_dbg), S_CLASSIFY);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        rst_n = 1'b1;

        chk("dut_queue_drained", 32'(q1.size()), 0);
        chk("dut2_queue_drained", 32'(q2.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
